// File: rtl/riscv_pkg.sv
// Shared pipeline control types for the stall sequencer and its consumers.
// Forwarding, hazard and MA logic read pipeline_ctrl_t fields.
package riscv_pkg;

  localparam logic [4:0] REG_X0 = 5'd0;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_MMIO_WAIT = 2'd1,
    ST_AMO_READ  = 2'd2,
    ST_AMO_WRITE = 2'd3
  } stall_state_e;

  typedef struct packed {
    logic stall;
    logic stall_for_load_use_hazard;
    logic load_use_hazard_detected;
    logic amo_read_phase;
    logic amo_write_enable;
    logic mmio_timeout;
    logic pipeline_reset;
  } pipeline_ctrl_t;

endpackage

// File: rtl/load_use_detector.sv
// Combinational load-use compare of EX rd against ID rs1/rs2.
// x0 never creates a hazard; unused operands are ignored.
module load_use_detector
  import riscv_pkg::*;
(
  input  logic       ex_is_mem_read,
  input  logic [4:0] ex_dest_reg,
  input  logic [4:0] id_source_reg_1,
  input  logic [4:0] id_source_reg_2,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  output logic       hazard
);

  logic rs1_hit;
  logic rs2_hit;
  logic rd_live;

  assign rs1_hit = id_uses_rs1
                 & (id_source_reg_1 == ex_dest_reg);
  assign rs2_hit = id_uses_rs2
                 & (id_source_reg_2 == ex_dest_reg);
  assign rd_live = ex_dest_reg != REG_X0;

  assign hazard = ex_is_mem_read
                & rd_live
                & (rs1_hit | rs2_hit);

endmodule

// File: rtl/pipeline_stall_sequencer.sv
// Pipeline stall/phase sequencer: load-use, MMIO wait, AMO phases.
// Also stretches the pipeline reset for a fixed hold window.
module pipeline_stall_sequencer
  import riscv_pkg::*;
#(
  parameter int MMIO_TIMEOUT_CYCLES = 64,
  parameter int RESET_HOLD_CYCLES   = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_ex_is_mem_read,
  input  logic [4:0] i_ex_dest_reg,
  input  logic [4:0] i_id_source_reg_1,
  input  logic [4:0] i_id_source_reg_2,
  input  logic       i_id_uses_rs1,
  input  logic       i_id_uses_rs2,
  input  logic       i_ma_mmio_load,
  input  logic       i_ma_amo,
  input  logic       i_mmio_rsp_valid,
  input  logic       i_flush,
  output logic       o_stall,
  output logic       o_stall_for_load_use_hazard,
  output logic       o_load_use_hazard_detected,
  output logic       o_amo_read_phase,
  output logic       o_amo_write_enable,
  output logic       o_mmio_timeout,
  output logic       o_pipeline_reset
);

  localparam int CW = (MMIO_TIMEOUT_CYCLES > 2)
                    ? $clog2(MMIO_TIMEOUT_CYCLES) : 1;
  localparam int HW = $clog2(RESET_HOLD_CYCLES + 1);
  localparam logic [CW-1:0] TO_LAST =
    CW'(MMIO_TIMEOUT_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST =
    HW'(RESET_HOLD_CYCLES);

  stall_state_e   state;
  logic [CW-1:0]  to_cnt;
  logic [HW-1:0]  hold_cnt;
  logic           pipe_rst;
  logic           lu_hit;
  logic           idle;
  logic           detect;
  logic           to_hit;
  pipeline_ctrl_t ctrl;

  load_use_detector u_lud (
    .ex_is_mem_read  (i_ex_is_mem_read),
    .ex_dest_reg     (i_ex_dest_reg),
    .id_source_reg_1 (i_id_source_reg_1),
    .id_source_reg_2 (i_id_source_reg_2),
    .id_uses_rs1     (i_id_uses_rs1),
    .id_uses_rs2     (i_id_uses_rs2),
    .hazard          (lu_hit)
  );

  assign idle   = (state == ST_IDLE) & ~pipe_rst;
  assign detect = lu_hit & idle & ~i_flush;

  // a response in the last wait cycle beats the timeout
  assign to_hit = (state == ST_MMIO_WAIT)
                & (to_cnt == TO_LAST)
                & ~i_mmio_rsp_valid;

  // Stretch reset: hold for RESET_HOLD_CYCLES edges after i_rst drops
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pipe_rst <= 1'b1;
      hold_cnt <= '0;
    end else if (pipe_rst) begin
      if (hold_cnt == HOLD_LAST) begin
        pipe_rst <= 1'b0;
      end else begin
        hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end

  // Sequencer FSM; flush never aborts an issued MMIO/AMO sequence
  always_ff @(posedge i_clk) begin
    if (i_rst || pipe_rst) begin
      state  <= ST_IDLE;
      to_cnt <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (i_ma_amo) begin
            state <= ST_AMO_READ;
          end else if (i_ma_mmio_load) begin
            state  <= ST_MMIO_WAIT;
            to_cnt <= '0;
          end
        end
        ST_MMIO_WAIT: begin
          if (i_mmio_rsp_valid || to_cnt == TO_LAST) begin
            state <= ST_IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        ST_AMO_READ: begin
          state <= ST_AMO_WRITE;
        end
        ST_AMO_WRITE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Output decode; everything but pipeline_reset is forced low in hold
  always_comb begin
    ctrl = '0;
    ctrl.pipeline_reset            = pipe_rst;
    ctrl.load_use_hazard_detected  = detect;
    ctrl.stall_for_load_use_hazard = detect;
    if (!pipe_rst) begin
      unique case (state)
        ST_IDLE: begin
          ctrl.stall = detect | i_ma_amo | i_ma_mmio_load;
        end
        ST_MMIO_WAIT: begin
          ctrl.stall        = 1'b1;
          ctrl.mmio_timeout = to_hit;
        end
        ST_AMO_READ: begin
          ctrl.stall          = 1'b1;
          ctrl.amo_read_phase = 1'b1;
        end
        ST_AMO_WRITE: begin
          ctrl.amo_write_enable = 1'b1;
        end
        default: begin
          ctrl.stall = 1'b0;
        end
      endcase
    end
  end

  assign o_stall                     = ctrl.stall;
  assign o_stall_for_load_use_hazard = ctrl.stall_for_load_use_hazard;
  assign o_load_use_hazard_detected  = ctrl.load_use_hazard_detected;
  assign o_amo_read_phase            = ctrl.amo_read_phase;
  assign o_amo_write_enable          = ctrl.amo_write_enable;
  assign o_mmio_timeout              = ctrl.mmio_timeout;
  assign o_pipeline_reset            = ctrl.pipeline_reset;

endmodule

// File: tb/tb_pipeline_stall_sequencer.sv
// Directed bench for pipeline_stall_sequencer with a per-cycle
// expected-output scoreboard sampled on the falling edge.
module tb_pipeline_stall_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       ex_mr;
  logic [4:0] ex_rd;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic       u1;
  logic       u2;
  logic       mmio;
  logic       amo;
  logic       rsp;
  logic       flush;
  logic       stall;
  logic       sflu;
  logic       lud;
  logic       amo_rd;
  logic       amo_we;
  logic       mto;
  logic       prst;

  localparam logic [6:0] N  = 7'b0000000;
  localparam logic [6:0] S  = 7'b1000000;
  localparam logic [6:0] SL = 7'b0100000;
  localparam logic [6:0] LD = 7'b0010000;
  localparam logic [6:0] AR = 7'b0001000;
  localparam logic [6:0] AW = 7'b0000100;
  localparam logic [6:0] TO = 7'b0000010;
  localparam logic [6:0] PR = 7'b0000001;

  typedef struct {
    logic [6:0] v;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pipeline_stall_sequencer #(
    .MMIO_TIMEOUT_CYCLES (4),
    .RESET_HOLD_CYCLES   (4)
  ) dut (
    .i_clk                       (clk),
    .i_rst                       (rst),
    .i_ex_is_mem_read            (ex_mr),
    .i_ex_dest_reg               (ex_rd),
    .i_id_source_reg_1           (rs1),
    .i_id_source_reg_2           (rs2),
    .i_id_uses_rs1               (u1),
    .i_id_uses_rs2               (u2),
    .i_ma_mmio_load              (mmio),
    .i_ma_amo                    (amo),
    .i_mmio_rsp_valid            (rsp),
    .i_flush                     (flush),
    .o_stall                     (stall),
    .o_stall_for_load_use_hazard (sflu),
    .o_load_use_hazard_detected  (lud),
    .o_amo_read_phase            (amo_rd),
    .o_amo_write_enable          (amo_we),
    .o_mmio_timeout              (mto),
    .o_pipeline_reset            (prst)
  );

  task automatic chk(input logic [6:0] ev,
                     input string tag);
    exp_t       e;
    logic [6:0] ob;
    sb.push_back('{v: ev, tag: tag});
    @(negedge clk);
    e  = sb.pop_front();
    ob = {stall, sflu, lud, amo_rd, amo_we, mto, prst};
    checks++;
    assert (ob === e.v) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b",
             e.tag, ob, e.v);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic lu(input logic mr, input logic [4:0] rd,
                    input logic [4:0] a, input logic [4:0] b,
                    input logic ua, input logic ub);
    ex_mr = mr;
    ex_rd = rd;
    rs1   = a;
    rs2   = b;
    u1    = ua;
    u2    = ub;
  endtask

  initial begin
    rst   = 1'b1;
    mmio  = 1'b0;
    amo   = 1'b0;
    rsp   = 1'b0;
    flush = 1'b0;
    lu(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;

    // reset held 3 edges, then 4 hold cycles
    for (int i = 0; i < 2; i++) chk(PR, "rst_in");
    rst = 1'b0;
    chk(PR, "rst_in");
    amo = 1'b1;
    lu(1'b1, 5'd5, 5'd0, 5'd5, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) chk(PR, "rst_hold");
    amo = 1'b0;
    lu(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    chk(N, "rst_done");

    // load-use
    lu(1'b1, 5'd5, 5'd0, 5'd5, 1'b0, 1'b1);
    chk(S | SL | LD, "lu_rs2");
    lu(1'b1, 5'd5, 5'd0, 5'd5, 1'b0, 1'b0);
    chk(N, "lu_nouse");
    lu(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
    chk(N, "lu_x0");
    lu(1'b1, 5'd7, 5'd7, 5'd1, 1'b1, 1'b0);
    chk(S | SL | LD, "lu_rs1");
    flush = 1'b1;
    chk(N, "lu_flush");
    flush = 1'b0;
    lu(1'b0, 5'd7, 5'd7, 5'd1, 1'b1, 1'b0);
    chk(N, "lu_noload");

    // MMIO with response in the third wait cycle
    mmio = 1'b1;
    chk(S, "mmio_c0");
    mmio = 1'b0;
    lu(1'b1, 5'd9, 5'd9, 5'd0, 1'b1, 1'b0);
    chk(S, "mmio_c1_lu_gated");
    lu(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    chk(S, "mmio_c2");
    rsp = 1'b1;
    chk(S, "mmio_c3_rsp");
    rsp = 1'b0;
    chk(N, "mmio_c4");
    rsp = 1'b1;
    chk(N, "rsp_in_idle");
    rsp = 1'b0;
    chk(N, "idle_after_rsp");

    // MMIO timeout
    mmio = 1'b1;
    chk(S, "to_c0");
    mmio = 1'b0;
    for (int i = 0; i < 3; i++) chk(S, "to_wait");
    chk(S | TO, "to_c4");
    chk(N, "to_c5");

    // response on the timeout cycle wins
    mmio = 1'b1;
    chk(S, "rto_c0");
    mmio = 1'b0;
    for (int i = 0; i < 3; i++) chk(S, "rto_wait");
    rsp = 1'b1;
    chk(S, "rto_c4");
    rsp = 1'b0;
    chk(N, "rto_c5");

    // AMO with a flush during the read phase
    amo = 1'b1;
    chk(S, "amo_c0");
    amo   = 1'b0;
    flush = 1'b1;
    chk(S | AR, "amo_c1");
    flush = 1'b0;
    chk(AW, "amo_c2");
    chk(N, "amo_c3");

    // AMO entry concurrent with load-use
    amo = 1'b1;
    lu(1'b1, 5'd3, 5'd3, 5'd0, 1'b1, 1'b0);
    chk(S | SL | LD, "amolu_c0");
    amo = 1'b0;
    chk(S | AR, "amolu_c1");
    chk(AW, "amolu_c2");
    chk(S | SL | LD, "amolu_c3");
    lu(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    chk(N, "amolu_c4");

    // reset while in MMIO_WAIT
    mmio = 1'b1;
    chk(S, "rmm_c0");
    mmio = 1'b0;
    rst  = 1'b1;
    chk(S, "rmm_c1");
    rst = 1'b0;
    for (int i = 0; i < 5; i++) chk(PR, "rmm_hold");
    chk(N, "rmm_idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_stall_sequencer.md
# pipeline_stall_sequencer

Generates the pipeline-wide stall, hazard and phase control bits that the forwarding unit, hazard logic and memory stage consume via `riscv_pkg::pipeline_ctrl_t`. It detects load-use hazards and sequences the multi-cycle MMIO-load and AMO read/write phases. It also holds the pipeline in reset for a fixed window after the external reset drops. It sits upstream of the forwarding unit and EX/MA stages: every stall/capture edge they see originates here.

## Interface
Parameters:
- `MMIO_TIMEOUT_CYCLES`, default 64: maximum cycles in MMIO_WAIT before forced release; must be ≥2.
- `RESET_HOLD_CYCLES`, default 4: cycles `o_pipeline_reset` stays high after `i_rst` deasserts; must be ≥1.

Ports:
- `i_clk`  in  1  clock; all logic on rising edge.
- `i_rst`  in  1  reset, synchronous, active-high.
- `i_ex_is_mem_read`  in  1  EX instruction is load, LR or AMO.
- `i_ex_dest_reg`  in  5  rd of EX instruction.
- `i_id_source_reg_1` / `i_id_source_reg_2`  in  5 each  rs1/rs2 of ID instruction.
- `i_id_uses_rs1` / `i_id_uses_rs2`  in  1 each  ID instruction reads that operand.
- `i_ma_mmio_load`  in  1  MA holds a load/LR addressed to the MMIO window.
- `i_ma_amo`  in  1  MA holds an AMO.
- `i_mmio_rsp_valid`  in  1  MMIO read data valid this cycle.
- `i_flush`  in  1  branch/trap flush of IF..ID.
- `o_stall`  out  1  freeze IF/PD/ID/EX registers.
- `o_stall_for_load_use_hazard`  out  1  stall caused by load-use; MA data captured for forwarding.
- `o_load_use_hazard_detected`  out  1  combinational load-use detect.
- `o_amo_read_phase`  out  1  AMO read phase; memory data valid.
- `o_amo_write_enable`  out  1  AMO write-back phase.
- `o_mmio_timeout`  out  1  one-cycle pulse on MMIO timeout.
- `o_pipeline_reset`  out  1  registered pipeline reset.

## Operation
- States: IDLE, MMIO_WAIT, AMO_READ, AMO_WRITE.
- Load-use, evaluated in IDLE only:
  - `detect = i_ex_is_mem_read & (i_ex_dest_reg != 0) & ((i_id_uses_rs1 & rs1 == rd) | (i_id_uses_rs2 & rs2 == rd)) & ~i_flush`.
  - Gated to 0 outside IDLE.
  - `o_stall_for_load_use_hazard = detect`.
  - One-cycle stall; no state change.
- IDLE with `i_ma_mmio_load`: `o_stall = 1` this cycle, then → MMIO_WAIT; clear the timeout counter.
- MMIO_WAIT: `o_stall = 1` every cycle, including the cycle `i_mmio_rsp_valid` is seen. That is the data-capture edge; → IDLE next.
  - The counter increments each cycle. At `MMIO_TIMEOUT_CYCLES-1` without a response: pulse `o_mmio_timeout`, keep `o_stall = 1` that cycle, → IDLE.
  - `i_mmio_rsp_valid` in IDLE is ignored.
- IDLE with `i_ma_amo`: `o_stall = 1`, → AMO_READ.
- AMO_READ: `o_stall = 1`, `o_amo_read_phase = 1`, → AMO_WRITE.
- AMO_WRITE: `o_amo_write_enable = 1`, `o_stall = 0`, → IDLE.
- Priority in IDLE: `i_ma_amo` > `i_ma_mmio_load` > load-use. Load-use may still assert `o_stall_for_load_use_hazard` in the same cycle; `o_stall` is the OR of all sources.
- `i_flush` does not abort MMIO_WAIT/AMO_*, because memory side effects are already issued. It only suppresses load-use detection.
- `o_stall = detect | (state==IDLE & (i_ma_amo | i_ma_mmio_load)) | state==MMIO_WAIT | state==AMO_READ`.

## Timing
- Reset: when `i_rst` is high, all of the following apply at the next edge:
  - state = IDLE, both counters cleared.
  - `o_pipeline_reset = 1`; all other outputs 0.
  - Reset mid-MMIO/AMO abandons the sequence.
- After `i_rst` falls, `o_pipeline_reset` stays 1 for exactly `RESET_HOLD_CYCLES` cycles (registered counter), then 0.
- While `o_pipeline_reset = 1`, all other outputs are forced 0 and the FSM stays IDLE.
- `o_load_use_hazard_detected`, `o_stall_for_load_use_hazard` and `o_stall` are combinational from inputs and state: 0-cycle latency.
- `o_amo_*` and `o_mmio_timeout` are decoded from registered state and counter.
- Minimum stall lengths:
  - Load-use: 1 cycle.
  - MMIO: 2 cycles (entry plus response in the first MMIO_WAIT cycle).
  - AMO: 2 cycles.
- MMIO maximum stall: `MMIO_TIMEOUT_CYCLES + 1`.
- Response and timeout in the same cycle: response wins; `o_mmio_timeout` stays 0.

## Structure
- `riscv_pkg` additions:
  - `stall_state_e` (2-bit enum of the four states).
  - Fields in `pipeline_ctrl_t` for `amo_read_phase`, `amo_write_enable` and `mmio_timeout`.
  - Constant `REG_X0 = 5'd0`.
- One natural sub-module: `load_use_detector`, the combinational rd/rs compare with x0 and use-enable gating. It is reusable by the hazard unit.
- Counters, FSM and output decode live in `pipeline_stall_sequencer`.

## Test plan
- Reset hold: `i_rst` high 3 cycles, then low.
  - Expect `o_pipeline_reset` = 1 for 3 + `RESET_HOLD_CYCLES` (4) cycles, then 0.
  - Expect all other outputs 0 throughout.
- Load-use detection:
  - EX load rd=5, ID rs2=5 with `uses_rs2` → `o_stall`, `o_stall_for_load_use_hazard` and `o_load_use_hazard_detected` = 1 for exactly that cycle.
  - rd=0 or `uses_rs2` = 0 → all 0.
- MMIO normal: `i_ma_mmio_load` at cycle 0, `i_mmio_rsp_valid` at cycle 3 → `o_stall` high cycles 0–3, low at cycle 4, `o_mmio_timeout` never pulses.
- MMIO timeout with `MMIO_TIMEOUT_CYCLES` = 4 and no response → `o_stall` high cycles 0–4, `o_mmio_timeout` = 1 only at cycle 4, IDLE at cycle 5.
- AMO plus flush: `i_ma_amo` at cycle 0 with `i_flush` at cycle 1 → stall cycles 0–1, `o_amo_read_phase` at cycle 1, `o_amo_write_enable` at cycle 2, not aborted.
- Simultaneous load-use and AMO entry in IDLE: AMO sequence proceeds; `o_stall_for_load_use_hazard` = 1 in the entry cycle only.
- `i_rst` during MMIO_WAIT → IDLE next edge, `o_stall` = 0.
